disp_7seg: RTL



---
 rtl/disp_7seg.sv | 104 ++++++++++
 1 files changed

// File: rtl/disp_7seg.sv
// Eight-digit multiplexed seven-segment driver with per-frame snapshot,
// leading-zero blanking and decimal-point control; outputs active-low.
module disp_7seg #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_reg,
  input  logic        blank_lz,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int unsigned CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_q, snap_d;
  logic          init_q, init_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;
  logic          tick, load, blank;
  logic [3:0]    nib;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    tick    = (cnt_q == CNT_MAX);
    load    = init_q | (tick & (idx_q == 3'd7));
    nib     = snap_q[{idx_q, 2'b00} +: 4];
    // digit k is a leading zero when every nibble from k upward is zero
    blank   = blank_lz && (idx_q != 3'd0) &&
              ((snap_q >> {idx_q, 2'b00}) == 32'd0);
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    idx_d   = tick ? idx_q + 3'd1 : idx_q;
    snap_d  = load ? data_reg : snap_q;
    init_d  = 1'b0;
    frame_d = load;
    an_d    = ~(8'b1 << idx_q);
    seg_d   = hex2seg(nib);
    dp_d    = ~dp_mask[idx_q];
    if (blank) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      snap_q  <= 32'd0;
      init_q  <= 1'b1;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      init_q  <= init_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule
